// File: rtl/pio_button.sv
// Avalon-MM parallel input port with edge capture and a maskable level interrupt.
// Inputs are two-flop synchronized; edgecapture is sticky and write-1-to-clear.
module pio_button #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s3;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_readdata;

    logic             w_wr;
    logic             w_wr_mask;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] w_rdmux;

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_mask = w_wr && (address == 2'd2);
    assign w_clear   = (w_wr && (address == 2'd3)) ? writedata : '0;

    always_comb begin
        w_event = '0;
        if (EDGE_TYPE == 0) begin
            w_event = r_s2 & ~r_s3;
        end else if (EDGE_TYPE == 1) begin
            w_event = ~r_s2 & r_s3;
        end else begin
            w_event = r_s2 ^ r_s3;
        end
    end

    always_comb begin
        w_rdmux = '0;
        case (address)
            2'd0:    w_rdmux = r_s2;
            2'd2:    w_rdmux = r_irqmask;
            2'd3:    w_rdmux = r_edgecap;
            default: w_rdmux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_readdata <= '0;
        end else begin
            r_s1       <= in_port;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_readdata <= w_rdmux;
            if (w_wr_mask) begin
                r_irqmask <= writedata;
            end
            // A new event overrides a simultaneous clear so no edge is lost.
            r_edgecap <= (r_edgecap & ~w_clear) | w_event;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_pio_button.sv
// Bench for pio_button: three instances (rising, falling, any edge) share stimulus;
// a delay-line reference model feeds a scoreboard checked by a separate monitor.
module tb_pio_button;

    logic       clk;
    logic       reset;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] in_port;
    logic [7:0] rd [3];
    logic [2:0] irq;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0][7:0] rd;
        logic [2:0]      irq;
    } exp_t;

    exp_t sb[$];

    // Reference state: last three input samples, per-mode mask and captured edges.
    logic [7:0] h0, h1, h2;
    logic [7:0] m_mask [3];
    logic [7:0] m_ec   [3];
    logic [7:0] pin;
    bit         stim_done = 0;

    pio_button #(.WIDTH(8), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[0]), .irq(irq[0])
    );
    pio_button #(.WIDTH(8), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[1]), .irq(irq[1])
    );
    pio_button #(.WIDTH(8), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[2]), .irq(irq[2])
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] edges(input int mode, input logic [7:0] nw,
                                         input logic [7:0] od);
        logic [7:0] e;
        for (int b = 0; b < 8; b++) begin
            case (mode)
                0:       e[b] = (nw[b] == 1'b1) && (od[b] == 1'b0);
                1:       e[b] = (nw[b] == 1'b0) && (od[b] == 1'b1);
                default: e[b] = (nw[b] != od[b]);
            endcase
        end
        return e;
    endfunction

    // One bus cycle: drive away from the edge, then advance the model at the edge.
    task automatic cyc(input logic cs, input logic wn, input logic [1:0] a,
                       input logic [7:0] wd, input logic rst);
        exp_t e;
        logic [7:0] clr;
        #1;
        chipselect = cs; write_n = wn; address = a; writedata = wd;
        in_port = pin; reset = rst;
        @(posedge clk);
        for (int m = 0; m < 3; m++) begin
            if (rst) begin
                e.rd[m]   = 8'h00;
                m_mask[m] = 8'h00;
                m_ec[m]   = 8'h00;
            end else begin
                case (a)
                    2'd0:    e.rd[m] = h1;
                    2'd2:    e.rd[m] = m_mask[m];
                    2'd3:    e.rd[m] = m_ec[m];
                    default: e.rd[m] = 8'h00;
                endcase
                clr     = (cs && !wn && a == 2'd3) ? wd : 8'h00;
                m_ec[m] = (m_ec[m] & ~clr) | edges(m, h1, h2);
                if (cs && !wn && a == 2'd2) m_mask[m] = wd;
            end
            e.irq[m] = |(m_ec[m] & m_mask[m]);
        end
        if (rst) begin
            h0 = 8'h00; h1 = 8'h00; h2 = 8'h00;
        end else begin
            h2 = h1; h1 = h0; h0 = pin;
        end
        sb.push_back(e);
    endtask

    task automatic rdc(input logic [1:0] a);
        cyc(1'b1, 1'b1, a, 8'h00, 1'b0);
    endtask

    task automatic wrc(input logic [1:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rdc(2'd3);
    endtask

    // Monitor: DUT outputs are valid every cycle, compared at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int m = 0; m < 3; m++) begin
                    chk($sformatf("sb_readdata[%0d]", m), rd[m], e.rd[m]);
                    chk($sformatf("sb_irq[%0d]", m), {7'd0, irq[m]}, {7'd0, e.irq[m]});
                end
            end
        end
    end

    initial begin
        h0 = 0; h1 = 0; h2 = 0;
        for (int m = 0; m < 3; m++) begin m_mask[m] = 0; m_ec[m] = 0; end
        pin = 8'h00;
        reset = 1; chipselect = 0; write_n = 1; address = 0; writedata = 0; in_port = 0;

        cyc(1'b0, 1'b1, 2'd0, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 2'd0, 8'h00, 1'b1);
        #2;
        chk("reset_readdata", rd[0], 8'h00);
        chk("reset_irq", {5'd0, irq}, 8'h00);

        // Rising capture with bit 0 masked in.
        wrc(2'd2, 8'h01);
        pin = 8'h01;
        idle(4);
        #2;
        chk("rise_ec", rd[0], 8'h01);
        chk("rise_irq", {7'd0, irq[0]}, 8'h01);
        chk("fall_mode_no_ec", rd[1], 8'h00);
        rdc(2'd0);
        #2;
        chk("data_read", rd[0], 8'h01);

        // Clear and mask.
        pin = 8'h05;
        idle(4);
        wrc(2'd2, 8'h04);
        wrc(2'd3, 8'h04);
        #2;
        chk("clear_irq0", {7'd0, irq[0]}, 8'h00);
        wrc(2'd2, 8'h01);
        #2;
        chk("remask_irq1", {7'd0, irq[0]}, 8'h01);
        rdc(2'd3);
        #2;
        chk("clear_ec", rd[0], 8'h01);

        // Simultaneous set and clear on bit 0.
        pin = 8'h04;
        idle(4);
        wrc(2'd3, 8'hFF);
        pin = 8'h05;
        idle(2);
        wrc(2'd3, 8'h01);
        rdc(2'd3);
        #2;
        chk("set_wins", rd[0], 8'h01);

        // Any-edge mode on bit 7, and falling edges ignored in rising mode.
        pin = 8'h80;
        idle(4);
        wrc(2'd3, 8'hFF);
        pin = 8'h00;
        idle(4);
        #2;
        chk("any_fall", rd[2], 8'h80);
        chk("rise_ignores_fall", rd[0], 8'h00);
        wrc(2'd3, 8'hFF);
        pin = 8'h80;
        idle(4);
        #2;
        chk("any_rise", rd[2], 8'h80);

        // Reset mid-operation with everything captured and masked.
        wrc(2'd2, 8'hFF);
        pin = 8'hFF;
        idle(4);
        pin = 8'h00;
        idle(4);
        #2;
        chk("full_irq", {5'd0, irq}, 8'h07);
        chk("full_ec", rd[2], 8'hFF);
        cyc(1'b0, 1'b1, 2'd0, 8'h00, 1'b1);
        #2;
        chk("mid_reset_irq", {5'd0, irq}, 8'h00);
        chk("mid_reset_rd", rd[0], 8'h00);
        idle(5);
        #2;
        chk("no_spurious", rd[0], 8'h00);
        rdc(2'd2);
        #2;
        chk("mask_cleared", rd[0], 8'h00);

        // Read latency and reserved address.
        wrc(2'd2, 8'h5A);
        rdc(2'd2);
        #2;
        chk("mask_read", rd[0], 8'h5A);
        rdc(2'd1);
        #2;
        chk("reserved_read", rd[1], 8'h00);

        // Inputs held high through reset produce a rising capture after release.
        pin = 8'h0F;
        cyc(1'b0, 1'b1, 2'd0, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 2'd0, 8'h00, 1'b1);
        idle(4);
        #2;
        chk("held_high_rise", rd[0], 8'h0F);
        chk("held_high_fall", rd[1], 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] flip;
            flip = 8'h00;
            if ($urandom_range(0, 3) == 0) flip = 8'(1 << $urandom_range(0, 7));
            pin = pin ^ flip;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 8'($urandom),
                ($urandom_range(0, 63) == 0));
        end

        idle(2);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
